// File: rtl/load_store_unit.sv
// Byte-addressed load/store unit in front of a word-addressed data memory.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic [31:0]       MEM_A,
    output logic [31:0]       MEM_WD,
    output logic [1:0]        MEM_RWE,
    input  logic [31:0]       MEM_RD,
    output logic [1:0]        DBG_STATE
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a response is held unchanged until it is taken.
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] idx_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] idx_in;
    logic        range_err;
    logic        align_err;
    logic        req_err;
    logic        accept;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign idx_in    = 32'(REQ_ADDR >> 2);
    assign range_err = idx_in >= 32'(MEM_WORDS);
`ifdef LSU_MISALIGN_CHECK_EN
    assign align_err = ((REQ_SIZE == 2'd1) && REQ_ADDR[0]) ||
                       ((REQ_SIZE == 2'd2) && (REQ_ADDR[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif
    assign req_err   = (REQ_SIZE == 2'd3) || range_err || align_err;
    assign accept    = REQ_VALID && REQ_READY;

    // Lane extraction ignores the low address bits a size does not use, so the
    // relaxed-alignment build needs no special casing here.
    always_comb begin
        lane_b    = MEM_RD[8*off_q +: 8];
        lane_h    = off_q[1] ? MEM_RD[31:16] : MEM_RD[15:0];
        load_data = MEM_RD;
        case (size_q)
            2'd0:    load_data = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    load_data = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = MEM_RD;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (size_q)
            2'd0:    merged[8*off_q +: 8] = wdata_q[7:0];
            2'd1:    merged[16*off_q[1] +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (REQ_WE && (REQ_SIZE == 2'd2))
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ:    state_nxt = we_q ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    if (RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            idx_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            word_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q       <= idx_in;
                        off_q       <= REQ_ADDR[1:0];
                        size_q      <= REQ_SIZE;
                        we_q        <= REQ_WE;
                        uns_q       <= REQ_UNSIGNED;
                        wdata_q     <= REQ_WDATA;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= req_err;
                    end
                end
                READ: begin
                    if (we_q)
                        word_q <= MEM_RD;
                    else
                        rsp_rdata_q <= load_data;
                end
                default: ;
            endcase
        end
    end

    assign REQ_READY = (state == IDLE) && RST_N;
    assign RSP_VALID = (state == RESP);
    assign RSP_RDATA = (state == RESP) ? rsp_rdata_q : 32'h0;
    assign RSP_ERR   = (state == RESP) && rsp_err_q;
    assign MEM_A     = ((state == READ) || (state == WRITE)) ? idx_q : 32'h0;
    assign MEM_WD    = (state == WRITE) ? merged : 32'h0;
    assign MEM_RWE   = (state == WRITE) ? 2'd3 : 2'd0;
    assign DBG_STATE = state;

endmodule
